// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction-fetch stage of a classic 5-stage pipeline. Holds the
//            PC register, selects the next PC (branch redirect > stall hold >
//            sequential PC+4), latches the fetched word into the IF/ID
//            register and keeps a saturating count of taken branches.
// Ports    : clk            - clock, all state updates on the rising edge
//            rst            - asynchronous active-high reset
//            PCSrc          - branch taken (from MEM-stage Branch & Zero)
//            branch_target  - branch address from EX/MEM (bits [1:0] ignored)
//            stall          - hazard-unit hold request
//            imem_addr      - instruction memory address (equals pc)
//            imem_data      - instruction word for imem_addr, same cycle
//            pc             - current PC register value
//            if_id_instr    - IF/ID latched instruction
//            if_id_pc_plus4 - IF/ID latched PC+4
//            if_id_valid    - IF/ID holds a real (non-squashed) instruction
//            branch_count   - saturating taken-branch counter
// Config   : FETCH_BRANCH_FLUSH_EN - when defined, a taken branch squashes
//            IF/ID to NOP_INSTR; when undefined the fetched word is kept
//            (delay-slot behaviour).
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrc,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [15:0] branch_count
);

    localparam logic [15:0] c_BC_MAX   = 16'hFFFF;
    // Reset PC is forced word-aligned so pc[1:0] is zero from the first cycle.
    localparam logic [31:0] c_RESET_PC = {RESET_PC[31:2], 2'b00};

    logic [31:0] r_pc_q,     w_pc_d;
    logic [31:0] r_instr_q,  w_instr_d;
    logic [31:0] r_pc4_q,    w_pc4_d;
    logic        r_valid_q,  w_valid_d;
    logic [15:0] r_bcnt_q,   w_bcnt_d;
    logic [31:0] w_pc_plus4;

    // Wraps naturally modulo 2^32.
    assign w_pc_plus4 = r_pc_q + 32'd4;

    always_comb begin
        w_pc_d    = r_pc_q;
        w_instr_d = r_instr_q;
        w_pc4_d   = r_pc4_q;
        w_valid_d = r_valid_q;
        w_bcnt_d  = r_bcnt_q;
        if (PCSrc) begin
            // Redirect wins over stall so a taken branch is never lost.
            w_pc_d = {branch_target[31:2], 2'b00};
            if (r_bcnt_q != c_BC_MAX) begin
                w_bcnt_d = r_bcnt_q + 16'd1;
            end
`ifdef FETCH_BRANCH_FLUSH_EN
            w_instr_d = NOP_INSTR;
            w_pc4_d   = 32'h0000_0000;
            w_valid_d = 1'b0;
`else
            w_instr_d = imem_data;
            w_pc4_d   = w_pc_plus4;
            w_valid_d = 1'b1;
`endif
        end else if (!stall) begin
            w_pc_d    = w_pc_plus4;
            w_instr_d = imem_data;
            w_pc4_d   = w_pc_plus4;
            w_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_q    <= c_RESET_PC;
            r_instr_q <= NOP_INSTR;
            r_pc4_q   <= 32'h0000_0000;
            r_valid_q <= 1'b0;
            r_bcnt_q  <= 16'h0000;
        end else begin
            r_pc_q    <= w_pc_d;
            r_instr_q <= w_instr_d;
            r_pc4_q   <= w_pc4_d;
            r_valid_q <= w_valid_d;
            r_bcnt_q  <= w_bcnt_d;
        end
    end

    assign imem_addr      = r_pc_q;
    assign pc             = r_pc_q;
    assign if_id_instr    = r_instr_q;
    assign if_id_pc_plus4 = r_pc4_q;
    assign if_id_valid    = r_valid_q;
    assign branch_count   = r_bcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage. Directed scenarios plus a
//            randomized run, all compared against a behavioural PC/IF-ID
//            model. Follows FETCH_BRANCH_FLUSH_EN the same way the DUT does.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSrc;
    logic [31:0] branch_target;
    logic        stall;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [15:0] branch_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [31:0] m_pc, m_instr, m_p4;
    logic        m_v;
    logic [15:0] m_bc;

    fetch_stage #(.RESET_PC(c_RESET_PC), .NOP_INSTR(c_NOP)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .PCSrc          (PCSrc),
        .branch_target  (branch_target),
        .stall          (stall),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .pc             (pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .branch_count   (branch_count)
    );

    always #5 clk = ~clk;

    // Address-derived instruction memory contents.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    always_comb imem_data = mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = c_RESET_PC; m_instr = c_NOP; m_p4 = 0; m_v = 0; m_bc = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    pc,             m_pc);
        check({tag, ".addr"},  imem_addr,      m_pc);
        check({tag, ".instr"}, if_id_instr,    m_instr);
        check({tag, ".pc4"},   if_id_pc_plus4, m_p4);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_v});
        check({tag, ".bcnt"},  {16'd0, branch_count}, {16'd0, m_bc});
    endtask

    // One clock edge: model follows the architectural rules, outputs are
    // compared on the following falling edge.
    task automatic cycle(input bit chk, input string tag);
        logic [31:0] word;
        @(posedge clk);
        word = mem_word(m_pc);
        if (PCSrc) begin
`ifdef FETCH_BRANCH_FLUSH_EN
            m_instr = c_NOP; m_p4 = 0; m_v = 0;
`else
            m_instr = word; m_p4 = m_pc + 4; m_v = 1;
`endif
            m_pc = {branch_target[31:2], 2'b00};
            if (m_bc != 16'hFFFF) m_bc = m_bc + 1;
        end else if (!stall) begin
            m_instr = word; m_p4 = m_pc + 4; m_v = 1;
            m_pc = m_pc + 4;
        end
        @(negedge clk);
        if (chk) check_all(tag);
    endtask

    task automatic drive(input logic s, input logic b, input logic [31:0] t);
        PCSrc = b; stall = s; branch_target = t;
    endtask

    logic [31:0] held_instr, held_p4;

    initial begin
        rst = 1'b1;
        drive(0, 0, 32'h0);
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Sequential fetch from reset.
        for (int i = 1; i <= 4; i++) begin
            cycle(1, "seq");
            check("seq.pc_lit",  pc, 32'(4 * i));
            check("seq.pc4_lit", if_id_pc_plus4, 32'(4 * i));
        end
        for (int i = 0; i < 4; i++) cycle(1, "seq2");
        check("pre_stall.pc", pc, 32'h20);

        // Stall hold.
        held_instr = if_id_instr; held_p4 = if_id_pc_plus4;
        drive(1, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, "stall");
            check("stall.pc_lit",    pc, 32'h20);
            check("stall.instr_lit", if_id_instr, held_instr);
            check("stall.pc4_lit",   if_id_pc_plus4, held_p4);
        end
        drive(0, 0, 32'h0);
        cycle(1, "unstall");
        check("unstall.pc_lit", pc, 32'h24);

        // Branch with simultaneous stall.
        drive(0, 1, 32'h40);
        cycle(1, "br40");
        drive(1, 1, 32'h103);
        cycle(1, "br_stall");
        check("br_stall.pc_lit", pc, 32'h100);
        check("br_stall.bcnt_lit", {16'd0, branch_count}, 32'd2);
`ifdef FETCH_BRANCH_FLUSH_EN
        check("br_stall.instr_lit", if_id_instr, c_NOP);
        check("br_stall.valid_lit", {31'd0, if_id_valid}, 32'd0);
`else
        check("br_stall.instr_lit", if_id_instr, mem_word(32'h40));
        check("br_stall.valid_lit", {31'd0, if_id_valid}, 32'd1);
`endif

        // PC wrap.
        drive(0, 1, 32'hFFFF_FFFE);
        cycle(1, "br_top");
        check("br_top.pc_lit", pc, 32'hFFFF_FFFC);
        drive(0, 0, 32'h0);
        cycle(1, "wrap");
        check("wrap.pc_lit",  pc, 32'h0);
        check("wrap.pc4_lit", if_id_pc_plus4, 32'h0);

        // Reset pulse between edges while redirecting.
        drive(0, 1, 32'h0000_0800);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_mid");
        rst = 1'b0;
        drive(0, 0, 32'h0);
        cycle(1, "post_rst");
        check("post_rst.pc_lit", pc, c_RESET_PC + 32'd4);
        check("post_rst.instr_lit", if_id_instr, mem_word(c_RESET_PC));

        // Randomized run with occasional asynchronous reset pulses.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom);
            if ($urandom_range(63) == 0) begin
                #1 rst = 1'b1;
                #1;
                model_reset();
                check_all("rnd_rst");
                rst = 1'b0;
            end
            cycle(1, "rnd");
        end

        // Saturation of the branch counter.
        rst = 1'b1; #1; model_reset(); rst = 1'b0;
        drive(0, 1, 32'h0000_0200);
        for (int i = 0; i < 65534; i++) cycle(0, "fill");
        check("sat.pre", {16'd0, branch_count}, 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) begin
            cycle(1, "sat");
            check("sat.lit", {16'd0, branch_count}, 32'h0000_FFFF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h0000_0000, the instruction word inserted into IF/ID on flush.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  is the reset, asynchronous and active-high.
REQ-005 Port PCSrc  input  1  is the branch-taken select from the MEM-stage Branch & Zero gate.
REQ-006 Port branch_target  input  32  is the branch address from the EX/MEM register.
REQ-007 Port stall  input  1  is the hazard-unit hold request.
REQ-008 Port imem_addr  output  32  is the instruction memory address.
REQ-009 Port imem_data  input  32  is the instruction word, combinationally valid for imem_addr in the same cycle.
REQ-010 Port pc  output  32  is the current PC register value.
REQ-011 Port if_id_instr  output  32  is the IF/ID latched instruction.
REQ-012 Port if_id_pc_plus4  output  32  is the IF/ID latched PC+4.
REQ-013 Port if_id_valid  output  1  marks if_id_instr as a real (non-squashed) instruction.
REQ-014 Port branch_count  output  16  is the saturating count of taken branches.

Function
REQ-015 imem_addr SHALL equal pc combinationally; no internal memory.
REQ-016 pc[1:0] SHALL always be 2'b00; branch_target[1:0] SHALL be ignored.
REQ-017 PC+4 SHALL be computed modulo 2^32 (32'hFFFF_FFFC + 4 wraps to 32'h0000_0000).
REQ-018 Next-PC priority SHALL be: PCSrc=1 -> {branch_target[31:2],2'b00}; else stall=1 -> hold pc; else pc+4.
REQ-019 PCSrc SHALL override stall in the same cycle (redirect is never lost).
REQ-020 Normal cycle (PCSrc=0, stall=0): IF/ID SHALL load if_id_instr<=imem_data, if_id_pc_plus4<=pc+4, if_id_valid<=1.
REQ-021 Stall cycle (stall=1, PCSrc=0): pc, if_id_instr, if_id_pc_plus4, if_id_valid SHALL all hold.
REQ-022 Fetch latency SHALL be one cycle: word at imem_addr in cycle N appears on if_id_instr after edge N.
REQ-023 branch_count SHALL increment by 1 on each rising edge with PCSrc=1, saturating at 16'hFFFF.
REQ-024 PCSrc held high for k consecutive cycles SHALL count k times and redirect each cycle.

Reset
REQ-025 rst=1 SHALL immediately, without a clock edge, set pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc_plus4=0, if_id_valid=0, branch_count=0.
REQ-026 Reset asserted mid-stall or mid-redirect SHALL discard the pending update; first edge after deassertion performs a normal fetch from RESET_PC.

Configuration
REQ-027 Macro FETCH_BRANCH_FLUSH_EN SHALL control IF/ID squash on taken branch.
REQ-028 Defined: an edge with PCSrc=1 SHALL load if_id_instr=NOP_INSTR, if_id_pc_plus4=0, if_id_valid=0 (regardless of stall).
REQ-029 Undefined: an edge with PCSrc=1 SHALL load IF/ID as in REQ-020 (delay-slot behaviour); if_id_valid=1.
REQ-030 PC redirect and branch_count behaviour SHALL be identical in both builds.

Verification
REQ-031 Reset release, imem_data=addr-derived pattern, 4 edges -> pc 0,4,8,C,10; if_id_pc_plus4 4,8,C,10; if_id_valid 0 then 1.
REQ-032 pc=32'h20, stall=1 for 3 edges -> pc stays 32'h20, IF/ID unchanged; stall=0 -> pc=32'h24.
REQ-033 pc=32'h40, PCSrc=1, branch_target=32'h103, stall=1 -> pc=32'h100, branch_count+1; flush build: if_id_valid=0, if_id_instr=NOP_INSTR; no-flush build: if_id_instr=word at 32'h40, if_id_valid=1.
REQ-034 pc forced to 32'hFFFF_FFFC, normal edge -> pc=32'h0, if_id_pc_plus4=32'h0.
REQ-035 Preload branch_count to 16'hFFFE, PCSrc=1 for 3 edges -> 16'hFFFF, 16'hFFFF, 16'hFFFF.
REQ-036 rst pulsed between clock edges while PCSrc=1 -> outputs at reset values before next edge; next edge after release fetches RESET_PC.
